// File: rtl/cpu_types_pkg.sv
// Shared decode-stage types.
//   extop_t     : immediate extension mode selector (2 bits)
//   BROFF_SHIFT : left shift applied to branch offsets (word -> byte)
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_BROFF = 2'd3
  } extop_t;

  localparam int BROFF_SHIFT = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension, all modes.
// Ports:
//   extop : extop_t mode (sign / zero / upper / branch offset)
//   imm   : raw IMM_W-bit immediate
//   ext   : DATA_W-bit extended operand
import cpu_types_pkg::*;

module ext_core #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [1:0]        extop,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;

  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};

  always_comb begin
    ext = sext;
    case (extop_t'(extop))
      EXT_SIGN:  ext = sext;
      EXT_ZERO:  ext = zext;
      EXT_UPPER: ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      // Bits pushed past DATA_W fall off; low bits fill with zero.
      EXT_BROFF: ext = sext << BROFF_SHIFT;
      default:   ext = sext;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extension with a 2-entry skid buffer (main + skid).
// Optional feature macro: EXT_BRTARGET_EN adds pc_in / brtarget, where
//   brtarget = pc_in + 4 + (sext(imm) << 2), carried alongside each entry.
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   flush             : drop all buffered entries next cycle
//   in_valid/in_ready : input handshake (in_ready depends on state only)
//   extop, imm, tag_in: mode, immediate, sideband tag
//   out_valid/out_ready: output handshake
//   extended, tag_out : head entry operand and tag
import cpu_types_pkg::*;

module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        extop,
  input  logic [IMM_W-1:0]  imm,
  input  logic [TAG_W-1:0]  tag_in,
`ifdef EXT_BRTARGET_EN
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] brtarget,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] extended,
  output logic [TAG_W-1:0]  tag_out
);

  logic [DATA_W-1:0] ext_new;

  ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_core (
    .extop (extop),
    .imm   (imm),
    .ext   (ext_new)
  );

  logic              main_vld_q,  main_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0]  main_tag_q,  main_tag_d;
  logic              skid_vld_q,  skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0]  skid_tag_q,  skid_tag_d;

`ifdef EXT_BRTARGET_EN
  logic [DATA_W-1:0] bt_new;
  logic [DATA_W-1:0] main_bt_q, main_bt_d;
  logic [DATA_W-1:0] skid_bt_q, skid_bt_d;

  assign bt_new = pc_in + DATA_W'(4)
                + ({{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} << BROFF_SHIFT);
  assign brtarget = main_bt_q;
`endif

  logic accept;
  logic drain;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign extended  = main_data_q;
  assign tag_out   = main_tag_q;

  // Flush wins over a same-cycle accept; an output transfer needs no action.
  assign accept = in_valid && in_ready && !flush;
  assign drain  = main_vld_q && out_ready;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
`ifdef EXT_BRTARGET_EN
    main_bt_d   = main_bt_q;
    skid_bt_d   = skid_bt_q;
`endif
    if (flush) begin
      // Only valids drop; payload registers keep their contents.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // in_ready is low here, so the only event is a drain refilling main.
      if (drain) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_tag_d  = skid_tag_q;
        skid_vld_d  = 1'b0;
`ifdef EXT_BRTARGET_EN
        main_bt_d   = skid_bt_q;
`endif
      end
    end else if (accept) begin
      if (!main_vld_q || drain) begin
        main_vld_d  = 1'b1;
        main_data_d = ext_new;
        main_tag_d  = tag_in;
`ifdef EXT_BRTARGET_EN
        main_bt_d   = bt_new;
`endif
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = ext_new;
        skid_tag_d  = tag_in;
`ifdef EXT_BRTARGET_EN
        skid_bt_d   = bt_new;
`endif
      end
    end else if (drain) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_vld_q  <= 1'b0;
      main_data_q <= '0;
      main_tag_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
`ifdef EXT_BRTARGET_EN
      main_bt_q   <= '0;
      skid_bt_q   <= '0;
`endif
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
`ifdef EXT_BRTARGET_EN
      main_bt_q   <= main_bt_d;
      skid_bt_q   <= skid_bt_d;
`endif
    end
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the decode stage of the MIPS datapath. It takes an IMM_W-bit immediate and a 2-bit mode, and produces a DATA_W-bit operand. It adds a branch-offset mode, a tag passthrough, and a valid/ready interface with a 2-entry skid buffer so decode can stall without losing operands. Flush support clears in-flight operands on branch mispredict.

Parameters:
DATA_W, 32, output word width; DATA_W >= IMM_W + 2
IMM_W, 16, immediate width
TAG_W, 5, sideband tag width (destination register index), passed through unmodified

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  synchronous active-high reset
flush  in  1  synchronous drop of all buffered entries
in_valid  in  1  input entry present
in_ready  out  1  unit can accept input this cycle
extop  in  2  extop_t mode
imm  in  IMM_W  raw immediate
tag_in  in  TAG_W  sideband tag
out_valid  out  1  output entry present
out_ready  in  1  consumer accepts output this cycle
extended  out  DATA_W  extended operand
tag_out  out  TAG_W  tag of current output entry

Behaviour:
- Modes (extop_t), all computed combinationally before registering:
  - EXT_SIGN=0: imm sign-extended to DATA_W.
  - EXT_ZERO=1: imm zero-extended.
  - EXT_UPPER=2: {imm, (DATA_W-IMM_W) zeros}.
  - EXT_BROFF=3: sign-extend, then shift left 2. Bits shifted past DATA_W are dropped; the low 2 bits are 0.
- Storage: main register (out stage) and skid register, each {valid, data, tag}.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !skid_valid, a registered function only; no combinational path from out_ready.
- Latency: 1 cycle. An input accepted in cycle N appears on out_valid/extended in cycle N+1 if main is empty or draining.
- Per-cycle update:
  - Main empty or draining, skid empty: accepted input goes to main.
  - Main full and not draining: accepted input goes to skid.
  - Main draining and skid full: skid moves to main. in_ready was low, so there is no simultaneous accept.
  - Simultaneous accept and drain with main full and skid empty: new entry replaces main.
- Ordering: strictly FIFO; no entry is duplicated or dropped except by flush.
- Flush:
  - Next cycle both valids are 0 and in_ready is 1.
  - Flush beats a same-cycle input accept; that input is discarded.
  - An output transfer in the flush cycle still completes.
- Reset: out_valid=0, in_ready=1 (skid_valid=0), extended=0, tag_out=0. Reset beats flush. Reset mid-transfer discards all entries.
- Data and tag registers hold their value when the slot is invalid; only valids are cleared by flush.
- extended and tag_out are stable whenever out_valid && !out_ready.

Optional Feature:
EXT_BRTARGET_EN:
- When defined, adds input pc_in (DATA_W) and output brtarget (DATA_W).
- pc_in is captured with each entry; brtarget = pc_in + 4 + (sext(imm) << 2), modulo 2^DATA_W.
- brtarget is computed for every mode and travels through main/skid with identical timing. Reset value is 0.
- When undefined, these ports, storage and adder are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gains typedef enum logic [1:0] extop_t {EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BROFF} and localparam BROFF_SHIFT = 2.
- One combinational sub-module, ext_core (parametrised DATA_W/IMM_W; extop, imm -> ext), holds all mode arithmetic.
- ext_pipe holds only the skid/handshake logic.

Test Plan:
- Modes, out_ready=1, imm=16'h8001: SIGN -> 32'hFFFF8001; ZERO -> 32'h00008001; UPPER -> 32'h80010000; BROFF -> 32'hFFFE0004. Each appears one cycle after accept.
- BROFF imm=16'hFFFF -> 32'hFFFFFFFC; imm=16'h7FFF -> 32'h0001FFFC; imm=0 in every mode -> 0.
- Backpressure: out_ready=0, inputs A,B,C on consecutive cycles. A is in main, B in skid, in_ready=0, C held. Raise out_ready: outputs A,B,C in order on consecutive cycles, tags matching, no gaps once C is accepted.
- Simultaneous accept and drain each cycle for 8 cycles: throughput 1 per cycle, in_ready constantly 1, output sequence equals input sequence delayed by 1.
- Flush with main and skid full plus in_valid=1: next cycle out_valid=0, in_ready=1, the flush-cycle input never appears. Reset asserted with both full: out_valid=0, extended=0 next cycle.
- With EXT_BRTARGET_EN: pc_in=32'h00400010, imm=16'hFFFE -> brtarget 32'h0040000C. Build without the macro compiles and passes all other tests.
